// File: rtl/if_fetch_queue_pkg.sv
// Shared types for the fetch stage: queue entries and the A/B issue slots.
package if_fetch_queue_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_out_t;

  typedef struct packed {
    if_out_t a;  // older
    if_out_t b;  // younger
  } if_out_n_t;

  // An invalid slot shows pc 0 and a NOP so decode never sees stale data.
  function automatic if_out_t slot_out(input logic valid, input fetch_entry_t e,
                                       input logic [31:0] nop);
    if_out_t s;
    s.valid = valid;
    s.pc    = valid ? e.pc : 32'h0;
    s.instr = valid ? e.instr : nop;
    return s;
  endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch stage boundary: imem request/response, redirect, and the two issue slots.
interface if_fetch_queue_if #(parameter int DEPTH = 8);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_rvalid;
  logic [63:0]   imem_rdata;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          take_a;
  logic          take_b;
  logic          out_a_valid;
  logic [31:0]   out_a_pc;
  logic [31:0]   out_a_instr;
  logic          out_b_valid;
  logic [31:0]   out_b_pc;
  logic [31:0]   out_b_instr;
  logic [CW-1:0] q_count;

  // The fetch stage itself
  modport slave (
    output imem_req, imem_addr,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, take_a, take_b,
    output out_a_valid, out_a_pc, out_a_instr, out_b_valid, out_b_pc, out_b_instr, q_count
  );

  // Memory + decode side
  modport master (
    input  imem_req, imem_addr,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, take_a, take_b,
    input  out_a_valid, out_a_pc, out_a_instr, out_b_valid, out_b_pc, out_b_instr, q_count
  );
endinterface

// File: rtl/if_fetch_queue_fifo.sv
// Circular entry buffer accepting 0-2 pushes and 0-2 pops per cycle, with flush.
module fetch_fifo_2w2r
  import if_fetch_queue_pkg::*;
#(
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [1:0]         push_n,     // push_data[0] goes first
  input  fetch_entry_t [1:0] push_data,
  input  logic [1:0]         pop_n,      // caller never pops more than count
  output fetch_entry_t       head0,
  output fetch_entry_t       head1,
  output logic [CW-1:0]      count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  // Entry storage; occupancy is tracked by count so no reset is needed here.
  always_ff @(posedge clk) begin
    if (!flush && push_n != 2'd0) begin
      mem[wr_ptr] <= push_data[0];
      if (push_n == 2'd2) mem[wr_ptr + AW'(1)] <= push_data[1];
    end
  end

  // Pointers and occupancy; flush empties the buffer and drops that cycle's traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop_n);
      wr_ptr <= wr_ptr + AW'(push_n);
      count  <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  assign head0 = mem[rd_ptr];
  assign head1 = mem[rd_ptr + AW'(1)];

endmodule

// File: rtl/if_fetch_queue.sv
// Dual-issue fetch: pair-aligned imem requests feeding an in-order A/B issue queue.
module if_fetch_queue
  import if_fetch_queue_pkg::fetch_entry_t, if_fetch_queue_pkg::if_out_n_t,
         if_fetch_queue_pkg::slot_out;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 8,
  parameter logic [31:0] NOP_INSTR = if_fetch_queue_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  if_fetch_queue_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]        fetch_pc, pend_addr, fetch_base;
  logic               pending, pending_epoch, epoch, skip_first;
  logic               req, rsp_ok, flush;
  logic [CW-1:0]      count;
  logic [1:0]         push_n, pop_n;
  fetch_entry_t [1:0] push_data;
  fetch_entry_t       head0, head1;
  if_out_n_t          slots;

  assign flush      = bus.redirect_valid;
  assign fetch_base = {fetch_pc[31:3], 3'b000};

  // Request only if the queue can absorb both the in-flight pair and a new one.
  always_comb begin
    req    = rst_n && !flush && (int'(count) + (pending ? 2 : 0) + 2 <= DEPTH);
    rsp_ok = bus.imem_rvalid && pending && (pending_epoch == epoch) && !flush;
    push_data[0] = '{pc: pend_addr,          instr: bus.imem_rdata[31:0]};
    push_data[1] = '{pc: pend_addr + 32'd4,  instr: bus.imem_rdata[63:32]};
    push_n       = 2'd0;
    if (rsp_ok) begin
      if (skip_first) begin
        // Fetched from an odd-word PC: the low word precedes the target.
        push_n       = 2'd1;
        push_data[0] = push_data[1];
      end else begin
        push_n = 2'd2;
      end
    end
  end

  // Issue slots straight off the queue head; B only pops alongside A.
  always_comb begin
    slots.a = slot_out((count != '0) && !flush, head0, NOP_INSTR);
    slots.b = slot_out((count > CW'(1)) && !flush, head1, NOP_INSTR);
    pop_n   = 2'd0;
    if (bus.take_a && slots.a.valid) pop_n = (bus.take_b && slots.b.valid) ? 2'd2 : 2'd1;
  end

  // Fetch PC, in-flight tracking and epoch; redirect wins over everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc      <= RESET_PC;
      pend_addr     <= '0;
      pending       <= 1'b0;
      pending_epoch <= 1'b0;
      epoch         <= 1'b0;
      skip_first    <= 1'b0;
    end else if (flush) begin
      fetch_pc <= bus.redirect_pc;
      pending  <= 1'b0;
      epoch    <= ~epoch;
    end else begin
      pending <= req;
      if (req) begin
        pend_addr     <= fetch_base;
        skip_first    <= fetch_pc[2];
        pending_epoch <= epoch;
        fetch_pc      <= fetch_base + 32'd8;
      end
    end
  end

  fetch_fifo_2w2r #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push_n    (push_n),
    .push_data (push_data),
    .pop_n     (pop_n),
    .head0     (head0),
    .head1     (head1),
    .count     (count)
  );

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_base;
  assign bus.out_a_valid = slots.a.valid;
  assign bus.out_a_pc    = slots.a.pc;
  assign bus.out_a_instr = slots.a.instr;
  assign bus.out_b_valid = slots.b.valid;
  assign bus.out_b_pc    = slots.b.pc;
  assign bus.out_b_instr = slots.b.instr;
  assign bus.q_count     = count;

endmodule
